// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute/writeback stage driving the register file write port.
// Define ALU_MUL_EN to add the iterative multiply (op 8); otherwise op 8 is illegal.
module alu_exec_stage #(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [2:0]       dst,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             write,
  output logic [2:0]       wr_Addr,
  output logic [WIDTH-1:0] wr_Data,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             illegal_op
);
  logic             accept, legal, is_mul, alu_cy, wb_en, wb_cy;
  logic             write_d, write_q, zf_d, zf_q, cf_d, cf_q, ill_d, ill_q;
  logic [WIDTH-1:0] alu_res, wb_data, data_d, data_q;
  logic [2:0]       wb_addr, addr_d, addr_q;
  logic [3:0]       sh;

  if (MUL_CYCLES != WIDTH) begin : g_cfg_chk
    $error("alu_exec_stage: MUL_CYCLES must equal WIDTH");
  end

  assign sh     = src_b[3:0];
  assign accept = in_valid & in_ready;

  // Shifts run through a WIDTH+1 vector so the extra bit holds the last bit shifted out.
  always_comb begin
    alu_res = '0;
    alu_cy  = 1'b0;
    legal   = 1'b1;
    is_mul  = 1'b0;
    case (op)
      4'd0: {alu_cy, alu_res} = {1'b0, src_a} + {1'b0, src_b};
      4'd1: begin
        alu_res = src_a - src_b;
        alu_cy  = src_a < src_b;
      end
      4'd2: alu_res = src_a & src_b;
      4'd3: alu_res = src_a | src_b;
      4'd4: alu_res = src_a ^ src_b;
      4'd5: alu_res = ~src_a;
      4'd6: {alu_cy, alu_res} = {1'b0, src_a} << sh;
      4'd7: {alu_res, alu_cy} = {src_a, 1'b0} >> sh;
`ifdef ALU_MUL_EN
      4'd8: is_mul = 1'b1;
`endif
      4'd9: alu_res = src_b;
      default: legal = 1'b0;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(MUL_CYCLES);
  typedef enum logic [1:0] {IDLE, MUL, MWB} state_t;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]         mdst_q, mdst_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               mul_done;

  assign in_ready = state_q != MUL;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mdst_d   = mdst_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mul_done = 1'b0;
    if (state_q == MUL) begin
      acc_d    = acc_q + (b_q[cnt_q] ? {{WIDTH{1'b0}}, a_q} << cnt_q : '0);
      cnt_d    = cnt_q + 1'b1;
      mul_done = cnt_q == CW'(MUL_CYCLES - 1);
      state_d  = mul_done ? MWB : MUL;
    end else if (accept & is_mul) begin
      state_d = MUL;
      a_d     = src_a;
      b_d     = src_b;
      mdst_d  = dst;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mdst_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mdst_q  <= mdst_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign in_ready = 1'b1;
`endif

  // The final multiply iteration takes over the write port; no op can be accepted then.
  always_comb begin
    wb_en   = accept & legal & ~is_mul;
    wb_addr = dst;
    wb_data = alu_res;
    wb_cy   = alu_cy;
`ifdef ALU_MUL_EN
    if (mul_done) begin
      wb_en   = 1'b1;
      wb_addr = mdst_q;
      wb_data = acc_d[WIDTH-1:0];
      wb_cy   = |acc_d[2*WIDTH-1:WIDTH];
    end
`endif
  end

  assign write_d = wb_en & ~wb_addr[2];
  assign ill_d   = accept & ~legal;
  assign addr_d  = write_d ? wb_addr : addr_q;
  assign data_d  = write_d ? wb_data : data_q;
  assign zf_d    = write_d ? ~|wb_data : zf_q;
  assign cf_d    = write_d ? wb_cy : cf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
      ill_q   <= ill_d;
    end
  end

  assign write      = write_q;
  assign wr_Addr    = addr_q;
  assign wr_Data    = data_q;
  assign zero_flag  = zf_q;
  assign carry_flag = cf_q;
  assign illegal_op = ill_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: scoreboard bench for alu_exec_stage; expected write/illegal events
// come from an arithmetic reference model and are matched by a separate monitor.
module tb_alu_exec_stage;
  localparam int MUL_CYCLES = 16;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [2:0]  dst = '0;
  logic [15:0] src_a = '0;
  logic [15:0] src_b = '0;
  logic        write;
  logic [2:0]  wr_Addr;
  logic [15:0] wr_Data;
  logic        zero_flag, carry_flag, illegal_op;

  alu_exec_stage #(.WIDTH(16), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .dst(dst), .src_a(src_a), .src_b(src_b),
    .write(write), .wr_Addr(wr_Addr), .wr_Data(wr_Data),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .illegal_op(illegal_op)
  );

  typedef struct {
    bit        ill;
    bit [2:0]  addr;
    bit [15:0] data;
    bit        z;
    bit        c;
    int        due;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  bit   mok;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   mz = 1'b0;
  bit   mc = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  function automatic void model(input bit [3:0] o, input bit [15:0] a, input bit [15:0] b,
                                output bit legal, output bit mul, output bit [15:0] r, output bit c);
    int        n;
    int        s;
    bit [31:0] p;
    n = int'(b[3:0]);
    legal = 1'b1;
    mul = 1'b0;
    r = '0;
    c = 1'b0;
    case (o)
      4'd0: begin s = a + b; r = s[15:0]; c = s[16]; end
      4'd1: begin r = a - b; c = a < b; end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin r = a << n; c = (n == 0) ? 1'b0 : a[16 - n]; end
      4'd7: begin r = a >> n; c = (n == 0) ? 1'b0 : a[n - 1]; end
      4'd8: begin
        if (MUL_EN) begin
          mul = 1'b1;
          p = {16'd0, a} * {16'd0, b};
          r = p[15:0];
          c = p[31:16] != 16'd0;
        end else begin
          legal = 1'b0;
        end
      end
      4'd9: r = b;
      default: legal = 1'b0;
    endcase
  endfunction

  task automatic issue(input bit [3:0] o, input bit [2:0] d, input bit [15:0] a, input bit [15:0] b,
                       output int waited);
    bit        legal, mul, c;
    bit [15:0] r;
    exp_t      e;
    op = o;
    dst = d;
    src_a = a;
    src_b = b;
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", waited);
    end
    model(o, a, b, legal, mul, r, c);
    e.ill = !legal;
    e.addr = d;
    e.data = r;
    e.due = cyc + 1 + (mul ? MUL_CYCLES : 0);
    if (!legal) begin
      e.z = mz;
      e.c = mc;
      exp_q.push_back(e);
    end else if (d < 3'd4) begin
      mz = (r == 16'd0);
      mc = c;
      e.z = mz;
      e.c = mc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_reset(input string name);
    tests++;
    if ({in_ready, write, wr_Addr, wr_Data, zero_flag, carry_flag, illegal_op} != 24'h80_0000) begin
      fails++;
      $display("FAIL %s: in_ready=%0b write=%0b wr_Addr=%0d wr_Data=%h zero=%0b carry=%0b illegal=%0b, required 1 0 0 0000 0 0 0",
               name, in_ready, write, wr_Addr, wr_Data, zero_flag, carry_flag, illegal_op);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && (write || illegal_op)) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: write=%0b illegal_op=%0b wr_Addr=%0d wr_Data=%h cycle=%0d, required no event",
                 write, illegal_op, wr_Addr, wr_Data, cyc);
      end else begin
        me = exp_q.pop_front();
        if (me.ill)
          mok = illegal_op && !write && zero_flag == me.z && carry_flag == me.c && cyc == me.due;
        else
          mok = write && !illegal_op && wr_Addr == me.addr && wr_Data == me.data &&
                zero_flag == me.z && carry_flag == me.c && cyc == me.due;
        if (!mok) begin
          fails++;
          $display("FAIL %s: got ill=%0b write=%0b addr=%0d data=%h z=%0b c=%0b cycle=%0d, expected ill=%0b addr=%0d data=%h z=%0b c=%0b cycle=%0d",
                   me.ill ? "illegal_pulse" : "write_pulse", illegal_op, write, wr_Addr, wr_Data,
                   zero_flag, carry_flag, cyc, me.ill, me.addr, me.data, me.z, me.c, me.due);
        end
      end
    end
  end

  function automatic bit [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int        w;
    bit [3:0]  ro;
    bit [2:0]  rd;
    bit [15:0] ra, rb;
    repeat (3) @(negedge clk);
    check_reset("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    issue(4'd0, 3'd2, 16'hFFFF, 16'h0001, w);
    issue(4'd1, 3'd1, 16'h0003, 16'h0005, w);
    issue(4'd6, 3'd0, 16'h8001, 16'h0001, w);
    issue(4'd7, 3'd3, 16'h0001, 16'h0000, w);
`ifdef ALU_MUL_EN
    issue(4'd8, 3'd3, 16'h0102, 16'h0300, w);
    issue(4'd9, 3'd1, 16'h1234, 16'h5678, w);
    tests++;
    if (w != MUL_CYCLES) begin
      fails++;
      $display("FAIL mul_backpressure: op after MUL waited %0d cycles, required %0d", w, MUL_CYCLES);
    end
`endif
    issue(4'd0, 3'd5, 16'h0001, 16'h0001, w);
    issue(4'd12, 3'd0, 16'h1111, 16'h2222, w);
    issue(4'd8, 3'd2, 16'h0007, 16'h0009, w);
`ifndef ALU_MUL_EN
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL in_ready_after_op8: in_ready=%0b, required 1", in_ready);
    end
`endif
    drain();
`ifdef ALU_MUL_EN
    issue(4'd8, 3'd1, 16'h1234, 16'h0F0F, w);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("reset_mid_mul");
    void'(exp_q.pop_back());
    mz = 1'b0;
    mc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
`endif
    for (int i = 0; i < 300; i++) begin
      ro = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      rd = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      issue(ro, rd, ra, rb, w);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
Execute/writeback stage directly downstream of the 4-entry, 16-bit register file. It takes the two read-port operands plus a decoded op and destination, computes the result, and drives the register file write port (write, wr_Addr, wr_Data) with a one-cycle pulse. Single-cycle ALU ops run back-to-back; the optional multiply is iterative and back-pressures the decoder through in_ready.

Parameters:
WIDTH, 16, operand/result width; must match the register file data width
MUL_CYCLES, 16, iteration count for the multiply; must equal WIDTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; asynchronous, active-low
in_valid  input  1  decoder presents an op this cycle
in_ready  output  1  stage can accept; an op transfers on a rising edge with in_valid & in_ready
op  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL, 7 SHR, 8 MUL, 9 MOV B, 10-15 illegal
dst  input  3  destination register address
src_a  input  WIDTH  operand A (register file rd_DataA)
src_b  input  WIDTH  operand B (register file rd_DataB)
write  output  1  register file write enable, one-cycle pulse
wr_Addr  output  3  register file write address
wr_Data  output  WIDTH  register file write data
zero_flag  output  1  last written result was zero
carry_flag  output  1  carry/borrow/shift-out of last written result
illegal_op  output  1  one-cycle pulse on acceptance of an illegal op

Behaviour:
- Reset (async, rst_n=0): state IDLE, in_ready=1, write=0, wr_Addr=0, wr_Data=0, zero_flag=0, carry_flag=0, illegal_op=0. Reset during MUL aborts it; no write is issued.
- States: IDLE, MUL, MWB.
- IDLE: in_ready=1. On accept of ops 0-7 or 9: result registered on the accept edge; write=1 for exactly the next cycle with wr_Addr=dst and wr_Data=result. Stays in IDLE, so one op per cycle is sustained with write high continuously.
- Accept edge with no valid op: write=0 next cycle. wr_Addr and wr_Data hold their last values.
- ADD: carry = bit 16 of A+B. SUB: A-B, carry = borrow (A<B unsigned).
- SHL/SHR: shift amount is src_b[3:0], logical, zero-fill. Amount 0 returns A unchanged with carry=0. Otherwise carry = last bit shifted out.
- AND, OR, XOR, NOT, MOV: carry=0.
- zero_flag and carry_flag update only on edges that set write=1 and hold otherwise.
- MUL: the accept edge latches A, B and dst, clears the accumulator, and moves to MUL with in_ready=0. Each MUL cycle adds A<<i when B[i]=1, for i=0..MUL_CYCLES-1, then moves to MWB on the edge after the last iteration. MWB: write=1, wr_Data = low WIDTH bits of the product, carry = 1 if the upper product bits are nonzero, in_ready=1. An op accepted during MWB is handled as from IDLE. Latency: write is high in cycle 17 after the accept edge.
- dst 4-7: the op executes normally but write stays 0 and the flags do not update (out-of-range register).
- Illegal op: illegal_op=1 for one cycle after the accept edge, write=0, flags unchanged, in_ready stays 1.

Optional Feature:
ALU_MUL_EN: when defined, op 8 behaves as the MUL above. When undefined, the MUL/MWB logic is absent, op 8 is treated as illegal (illegal_op pulse, no write), and in_ready is tied 1.

Test Plan:
- Reset mid-MUL: assert rst_n=0 at cycle 5 of a MUL -> all outputs 0, in_ready=1, no write pulse afterwards.
- ADD A=0xFFFF, B=0x0001, dst=2 -> next cycle write=1, wr_Addr=2, wr_Data=0x0000, zero=1, carry=1. Then SUB A=3, B=5, dst=1 on the next cycle -> wr_Data=0xFFFE, carry=1, zero=0, with write high both cycles.
- SHL A=0x8001, B=0x0001 -> wr_Data=0x0002, carry=1. SHR A=0x0001, B=0 -> wr_Data=0x0001, carry=0.
- MUL (ALU_MUL_EN) A=0x0102, B=0x0300, dst=3 -> in_ready=0 for 16 cycles, write in cycle 17 with wr_Data=0x0600, carry=1. in_valid held high throughout -> the next op is accepted only in MWB.
- ADD with dst=5 -> write stays 0, flags unchanged. op=12 -> illegal_op one-cycle pulse, no write.
- Build without ALU_MUL_EN, op=8 -> illegal_op pulse, no write, in_ready stays 1.
